// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter that forwards whole packets from two
// byte-stream requesters (FIB, PIT return path) to a single SPI transmit port.
// Packet length comes from meta bit 6 (interest vs data); a packet is never
// truncated once granted, and a grant always passes through IDLE.
module spi_tx_arbiter #(
    parameter int INTEREST_BYTES = 17,
    parameter int DATA_BYTES     = 41
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] in_byte0,
    input  logic [7:0] in_byte1,
    input  logic [1:0] in_valid,
    output logic [1:0] in_ready,
    output logic [1:0] gnt,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       pkt_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_META = 2'd1,
        ST_BODY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Remaining-byte counts loaded after the meta byte has gone out.
    localparam logic [5:0] INTEREST_LEN_M1 = 6'(INTEREST_BYTES - 1);
    localparam logic [5:0] DATA_LEN_M1     = 6'(DATA_BYTES - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic       cur_idx_r;
    logic       last_idx_r;
    logic       win_idx_s;
    logic       sel_idx_s;
    logic [1:0] gnt_next_s;
    logic [5:0] cnt_r;
    logic [1:0] gnt_r;
    logic       pkt_done_r;
    logic       active_s;
    logic       xfer_s;
    logic       last_xfer_s;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        win_idx_s = 1'b0;
        case (req)
            2'b01:   win_idx_s = 1'b0;
            2'b10:   win_idx_s = 1'b1;
            2'b11:   win_idx_s = ~last_idx_r;
            default: win_idx_s = 1'b0;
        endcase
        if (state_r == ST_IDLE) begin
            sel_idx_s = win_idx_s;
        end else begin
            sel_idx_s = cur_idx_r;
        end
        if ((next_state_s == ST_META) || (next_state_s == ST_BODY)) begin
            gnt_next_s = sel_idx_s ? 2'b10 : 2'b01;
        end else begin
            gnt_next_s = 2'b00;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: packet ends on byte count, never on req.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    next_state_s = ST_META;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_META: begin
                if (xfer_s) begin
                    next_state_s = ST_BODY;
                end else begin
                    next_state_s = ST_META;
                end
            end
            ST_BODY: begin
                if (last_xfer_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_BODY;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output logic: byte path is a combinational mux of the granted requester.
    always_comb begin
        active_s = (state_r == ST_META) || (state_r == ST_BODY);
        if (active_s) begin
            tx_valid = in_valid[cur_idx_r];
            tx_byte  = cur_idx_r ? in_byte1 : in_byte0;
            in_ready = cur_idx_r ? {tx_ready, 1'b0} : {1'b0, tx_ready};
        end else begin
            tx_valid = 1'b0;
            tx_byte  = 8'h00;
            in_ready = 2'b00;
        end
        xfer_s      = tx_valid && tx_ready;
        // A zero count is treated as last too, so the counter cannot wrap.
        last_xfer_s = xfer_s && (state_r == ST_BODY) && (cnt_r <= 6'd1);
    end

    // Grant, done pulse, round-robin history and byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_idx_r  <= 1'b0;
            last_idx_r <= 1'b1;
            cnt_r      <= 6'd0;
            gnt_r      <= 2'b00;
            pkt_done_r <= 1'b0;
        end else begin
            pkt_done_r <= (next_state_s == ST_DONE);
            gnt_r      <= gnt_next_s;
            cur_idx_r  <= sel_idx_s;
            if (state_r == ST_DONE) begin
                last_idx_r <= cur_idx_r;
            end
            if ((state_r == ST_META) && xfer_s) begin
                cnt_r <= tx_byte[6] ? INTEREST_LEN_M1 : DATA_LEN_M1;
            end else if ((state_r == ST_BODY) && xfer_s) begin
                cnt_r <= cnt_r - 6'd1;
            end
        end
    end

    assign gnt      = gnt_r;
    assign pkt_done = pkt_done_r;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Testbench for spi_tx_arbiter: table of directed packets, a reset-abort
// sequence, then randomized packets checked against a packet-level model
// (round-robin winner, length from meta bit 6, byte order from a stored image).
module tb_spi_tx_arbiter;

    localparam int IB = 17;
    localparam int DB = 41;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] in_byte0;
    logic [7:0] in_byte1;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] gnt;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       pkt_done;

    int checks   = 0;
    int failures = 0;
    int last_win;
    logic [7:0] pkt [2][64];

    typedef struct {
        logic [1:0] req;
        logic [7:0] meta0;
        logic [7:0] meta1;
        int         rdy_mode;
        int         vld_mode;
        int         drop_after;
        logic [1:0] exp_gnt;
        int         exp_len;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    spi_tx_arbiter #(.INTEREST_BYTES(IB), .DATA_BYTES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .in_byte0 (in_byte0),
        .in_byte1 (in_byte1),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .gnt      (gnt),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .pkt_done (pkt_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pkt_len(input logic [7:0] meta);
        return meta[6] ? IB : DB;
    endfunction

    function automatic int rr_winner(input logic [1:0] r, input int last);
        if (r == 2'b11) return 1 - last;
        else if (r == 2'b01) return 0;
        else return 1;
    endfunction

    task automatic load_pkt(input int g, input logic [7:0] meta);
        pkt[g][0] = meta;
        for (int i = 1; i < 64; i++) pkt[g][i] = 8'($urandom);
    endtask

    // Caller is #1 after an edge with the DUT idle and req already set.
    // rst_at >= 0 pulses reset once that many bytes have transferred.
    task automatic run_packet(input logic [1:0] exp_gnt, input int exp_len,
                              input int rdy_mode, input int vld_mode,
                              input int drop_after, input int rst_at);
        int   g;
        int   ptr;
        int   cyc;
        logic xfer;
        logic aborted;
        g       = exp_gnt[1] ? 1 : 0;
        ptr     = 0;
        cyc     = 0;
        aborted = 1'b0;
        @(posedge clk); #1;
        chk("grant_latency", {30'd0, gnt}, {30'd0, exp_gnt});
        while (ptr < exp_len && cyc < 600) begin
            if (rst_at >= 0 && ptr == rst_at) begin
                aborted = 1'b1;
                break;
            end
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = cyc[0];
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            in_valid[g]     = (vld_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid[1 - g] = 1'($urandom_range(0, 1));
            if (g == 0) begin
                in_byte0 = pkt[0][ptr];
                in_byte1 = 8'($urandom);
            end else begin
                in_byte1 = pkt[1][ptr];
                in_byte0 = 8'($urandom);
            end
            if (drop_after > 0 && ptr >= drop_after) req[g] = 1'b0;
            if (rdy_mode == 2) req[1 - g] = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("gnt_hold", {30'd0, gnt}, {30'd0, exp_gnt});
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, in_valid[g]});
            chk("tx_byte", {24'd0, tx_byte}, {24'd0, pkt[g][ptr]});
            chk("in_ready", {30'd0, in_ready}, {30'd0, (tx_ready ? exp_gnt : 2'b00)});
            chk("no_early_done", {31'd0, pkt_done}, 32'd0);
            xfer = in_valid[g] && tx_ready;
            @(posedge clk); #1;
            if (xfer) ptr++;
            cyc++;
        end
        in_valid = 2'b11;
        tx_ready = 1'b1;
        if (aborted) begin
            req = 2'b00;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            last_win = 1;
            chk("abort_gnt", {30'd0, gnt}, 32'd0);
            chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
            chk("abort_in_ready", {30'd0, in_ready}, 32'd0);
            chk("abort_no_done", {31'd0, pkt_done}, 32'd0);
            @(posedge clk); #1;
            chk("abort_no_done_later", {31'd0, pkt_done}, 32'd0);
        end else if (ptr < exp_len) begin
            chk("packet_timeout_bytes", ptr, exp_len);
            req = 2'b00;
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            last_win = 1;
        end else begin
            // DONE cycle: pulse visible, byte path closed.
            @(negedge clk);
            chk("pkt_done_pulse", {31'd0, pkt_done}, 32'd1);
            chk("done_tx_valid", {31'd0, tx_valid}, 32'd0);
            chk("done_in_ready", {30'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            chk("idle_pkt_done", {31'd0, pkt_done}, 32'd0);
            chk("idle_gnt", {30'd0, gnt}, 32'd0);
            chk("idle_tx_valid", {31'd0, tx_valid}, 32'd0);
            last_win = g;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] r;
        int         w;
        int         rm;
        int         vm;
        int         dr;

        vecs[0] = '{2'b11, 8'h08, 8'h48, 0, 0, 0, 2'b01, 41};
        vecs[1] = '{2'b11, 8'h08, 8'h48, 0, 0, 0, 2'b10, 17};
        vecs[2] = '{2'b01, 8'h08, 8'h48, 1, 0, 0, 2'b01, 41};
        vecs[3] = '{2'b01, 8'h48, 8'h08, 0, 0, 5, 2'b01, 17};
        vecs[4] = '{2'b10, 8'h08, 8'hC8, 0, 1, 0, 2'b10, 17};
        vecs[5] = '{2'b11, 8'hBF, 8'h48, 2, 1, 0, 2'b01, 41};
        vecs[6] = '{2'b10, 8'h00, 8'h7F, 2, 0, 0, 2'b10, 17};
        vecs[7] = '{2'b11, 8'h40, 8'h00, 1, 1, 0, 2'b01, 17};

        rst      = 1'b1;
        req      = 2'b00;
        in_valid = 2'b11;
        tx_ready = 1'b1;
        in_byte0 = 8'hA5;
        in_byte1 = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", {30'd0, gnt}, 32'd0);
        chk("reset_pkt_done", {31'd0, pkt_done}, 32'd0);
        chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("reset_in_ready", {30'd0, in_ready}, 32'd0);
        rst      = 1'b0;
        last_win = 1;

        for (int i = 0; i < 8; i++) begin
            load_pkt(0, vecs[i].meta0);
            load_pkt(1, vecs[i].meta1);
            req = vecs[i].req;
            run_packet(vecs[i].exp_gnt, vecs[i].exp_len, vecs[i].rdy_mode,
                       vecs[i].vld_mode, vecs[i].drop_after, -1);
        end

        // Reset at byte 20 of a data packet, then a fresh packet from requester 1.
        load_pkt(0, 8'h08);
        req = 2'b01;
        run_packet(2'b01, DB, 0, 0, 0, 20);
        load_pkt(1, 8'h88);
        req = 2'b10;
        run_packet(2'b10, DB, 0, 0, 0, -1);

        // Randomized packets against the packet-level model.
        for (int n = 0; n < 25; n++) begin
            r  = 2'($urandom_range(1, 3));
            load_pkt(0, 8'($urandom));
            load_pkt(1, 8'($urandom));
            w  = rr_winner(r, last_win);
            rm = $urandom_range(0, 2);
            vm = $urandom_range(0, 1);
            dr = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
            req = r;
            run_packet((w == 1) ? 2'b10 : 2'b01, pkt_len(pkt[w][0]), rm, vm, dr, -1);
        end

        req = 2'b00;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 SHALL have parameter INTEREST_BYTES, default 17, meaning total bytes in an interest packet (1 meta + 8 prefix + 8 matching prefix).
REQ-002 SHALL have parameter DATA_BYTES, default 41, meaning total bytes in a data packet (1 meta + 8 prefix + 32 data).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  2  per-requester packet-pending flag (bit 0 = FIB, bit 1 = PIT return path).
REQ-006 SHALL have ports in_byte0, in_byte1  input  8 each  requester packet byte, meta byte first, MSB-first field order.
REQ-007 SHALL have port in_valid  input  2  per-requester byte-valid.
REQ-008 SHALL have port in_ready  output  2  per-requester byte accepted this cycle.
REQ-009 SHALL have port gnt  output  2  one-hot current grant; 0 when idle.
REQ-010 SHALL have port tx_byte  output  8  byte toward the SPI transmit side.
REQ-011 SHALL have port tx_valid  output  1  tx_byte valid.
REQ-012 SHALL have port tx_ready  input  1  SPI side accepts byte this cycle.
REQ-013 SHALL have port pkt_done  output  1  one-cycle pulse in the cycle after the last byte of a packet transfers.

Function
REQ-014 SHALL implement states IDLE, META, BODY, DONE.
REQ-015 IDLE: if req != 0, SHALL register one-hot gnt and enter META the next cycle; else remain in IDLE with gnt = 0.
REQ-016 Arbitration SHALL be round-robin: the requester not granted last wins when both requests are set; a single request wins immediately.
REQ-017 Byte transfer SHALL occur only in META/BODY, in any cycle where in_valid[g] and tx_ready are both 1 (g = granted index).
REQ-018 tx_valid SHALL equal in_valid[g] and tx_byte SHALL equal in_byte<g> combinationally in META/BODY; tx_valid = 0 and tx_byte = 0 otherwise.
REQ-019 in_ready[g] SHALL equal tx_ready in META/BODY; the non-granted in_ready bit and all in_ready bits outside META/BODY SHALL be 0.
REQ-020 META: on transfer SHALL latch meta bit 6 (1 = interest) and load the 6-bit remaining counter with INTEREST_BYTES-1 or DATA_BYTES-1, then enter BODY.
REQ-021 BODY: each transfer SHALL decrement the remaining counter; the transfer with counter = 1 SHALL be the last, and the state SHALL move to DONE.
REQ-022 DONE: SHALL pulse pkt_done for one cycle, clear gnt, record the last-granted index, and return to IDLE.
REQ-023 No stall limit: in_valid or tx_ready low SHALL hold state and counter indefinitely.
REQ-024 Deassertion of req[g] mid-packet SHALL be ignored; the packet SHALL complete by byte count and is never truncated.
REQ-025 A request arriving during a packet SHALL wait; grant changes only via IDLE, giving at least one idle cycle between packets.
REQ-026 Meta bits [7] and [5:0] SHALL be passed through unmodified and SHALL not affect the byte count.

Reset
REQ-027 With rst = 1 at a clock edge, SHALL go to IDLE, gnt = 0, pkt_done = 0, counter = 0, last-granted = requester 1 (requester 0 wins the first tie).
REQ-028 Reset mid-packet SHALL abandon the packet with no pkt_done pulse; in_ready and tx_valid SHALL be 0 in the cycle after the reset edge.

Verification
REQ-029 Reset, req = 2'b11 -> gnt = 2'b01 one cycle later; after requester 0 packet completes and req stays 11, next gnt = 2'b10.
REQ-030 Requester 1 sends interest (meta 0x48), tx_ready = 1, in_valid = 1 -> exactly 17 tx transfers, pkt_done one cycle after the 17th.
REQ-031 Requester 0 sends data packet (meta 0x08) -> exactly 41 transfers with bytes matching the input in order, then pkt_done.
REQ-032 tx_ready toggled every other cycle during data packet -> still 41 transfers, no duplicated or dropped bytes, in_ready mirrors tx_ready.
REQ-033 req[0] dropped after byte 5 of an interest packet -> remaining 12 bytes still transferred, pkt_done asserted.
REQ-034 rst pulsed at byte 20 of a data packet -> gnt = 0, no pkt_done, next req = 2'b10 granted to requester 1 and packet restarts at its meta byte.
